// File: rtl/iir_sample_ctrl.sv
// Sample sequencer and shadow/active coefficient bank for the 12th-order IIR datapath.
// One filt_step per accepted sample; bank swaps happen only between samples and clear filter history.
module iir_sample_ctrl #(
  parameter int DATA_W = 32,
  parameter int NCOEF  = 25,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic signed [DATA_W-1:0] m_data,
  input  logic                     m_ready,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]        cfg_wdata,
  input  logic                     cfg_commit,
  output logic                     cfg_busy,
  output logic signed [DATA_W-1:0] filt_x,
  input  logic signed [DATA_W-1:0] filt_y,
  output logic                     filt_step,
  output logic                     filt_clear,
  output logic [NCOEF*DATA_W-1:0]  coef_bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_OUT,
    ST_SWAP
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCOEF - 1);

  state_t                     state_q, state_d;
  logic                       commit_pend_q, commit_pend_d;
  logic                       m_valid_q, m_valid_d;
  logic signed [DATA_W-1:0]   filt_x_q, filt_x_d;
  logic signed [DATA_W-1:0]   m_data_q, m_data_d;
  logic        [DATA_W-1:0]   shadow_q [NCOEF];
  logic        [DATA_W-1:0]   shadow_d [NCOEF];
  logic        [DATA_W-1:0]   active_q [NCOEF];
  logic        [DATA_W-1:0]   active_d [NCOEF];
  logic                       addr_ok;

  assign addr_ok = (cfg_addr <= LAST_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      commit_pend_q <= 1'b0;
      m_valid_q     <= 1'b0;
      filt_x_q      <= '0;
      m_data_q      <= '0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
    end else begin
      state_q       <= state_d;
      commit_pend_q <= commit_pend_d;
      m_valid_q     <= m_valid_d;
      filt_x_q      <= filt_x_d;
      m_data_q      <= m_data_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    commit_pend_d = commit_pend_q;
    m_valid_d     = m_valid_q;
    filt_x_d      = filt_x_q;
    m_data_d      = m_data_q;
    shadow_d      = shadow_q;
    active_d      = active_q;

    // A write in the same cycle as the commit lands first, so it is part of the swapped bank.
    if (cfg_we && !commit_pend_q && addr_ok) begin
      shadow_d[cfg_addr] = cfg_wdata;
    end
    if (cfg_commit && !commit_pend_q) begin
      commit_pend_d = 1'b1;
    end

    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (commit_pend_q) begin
          state_d = ST_SWAP;
        end else if (s_valid) begin
          filt_x_d = s_data;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        m_data_d  = filt_y;
        m_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_SWAP: begin
        active_d      = shadow_q;
        commit_pend_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // INIT's clear is gated by reset so the strobe only appears in the first cycle after release.
  assign filt_clear = (state_q == ST_SWAP) || ((state_q == ST_INIT) && !reset);
  assign filt_step  = (state_q == ST_CALC);
  assign s_ready    = (state_q == ST_IDLE) && !commit_pend_q;
  assign cfg_busy   = commit_pend_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign filt_x     = filt_x_q;

  for (genvar k = 0; k < NCOEF; k++) begin : g_coef
    assign coef_bus[k*DATA_W +: DATA_W] = active_q[k];
  end

endmodule

// File: tb/tb_iir_sample_ctrl.sv
// Directed bench for iir_sample_ctrl: transaction-level scoreboard plus hand-computed expectations.
// The filter is stood in for by filt_y = 3*filt_x + b1 so the bank in use is visible in m_data.
module tb_iir_sample_ctrl;
  localparam int DATA_W = 32;
  localparam int NCOEF  = 25;
  localparam int ADDR_W = 5;

  logic                     clk;
  logic                     reset;
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_data;
  logic                     s_ready;
  logic                     m_valid;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_ready;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [DATA_W-1:0]        cfg_wdata;
  logic                     cfg_commit;
  logic                     cfg_busy;
  logic signed [DATA_W-1:0] filt_x;
  logic signed [DATA_W-1:0] filt_y;
  logic                     filt_step;
  logic                     filt_clear;
  logic [NCOEF*DATA_W-1:0]  coef_bus;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  iir_sample_ctrl #(.DATA_W(DATA_W), .NCOEF(NCOEF), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .filt_x(filt_x), .filt_y(filt_y),
    .filt_step(filt_step), .filt_clear(filt_clear),
    .coef_bus(coef_bus)
  );

  assign filt_y = filt_x * 3 + $signed(coef_bus[DATA_W-1:0]);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  logic [DATA_W-1:0] mshadow [NCOEF];
  logic [DATA_W-1:0] mactive [NCOEF];
  logic [DATA_W-1:0] mcommit [NCOEF];
  logic              mpend;
  logic              swap_next;
  logic [DATA_W-1:0] expq [$];
  logic [DATA_W-1:0] got [$];
  int                accepts, steps, acc_cyc;
  logic [DATA_W-1:0] last_acc;
  logic              prev_mv;
  logic [DATA_W-1:0] prev_md;

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCOEF; k++) begin
        mshadow[k] = '0; mactive[k] = '0; mcommit[k] = '0;
      end
      mpend = 1'b0; swap_next = 1'b0; expq.delete();
      steps = accepts; prev_mv = 1'b0; prev_md = '0;
    end else begin
      if (swap_next) begin
        for (int k = 0; k < NCOEF; k++) mactive[k] = mcommit[k];
        swap_next = 1'b0;
      end
      begin : coef_cmp
        int bad;
        bad = -1;
        for (int k = 0; k < NCOEF; k++)
          if (bad < 0 && coef_bus[k*DATA_W +: DATA_W] !== mactive[k]) bad = k;
        checks++;
        if (bad >= 0) begin
          failures++;
          $display("FAIL coef_bus[%0d] got=%0d exp=%0d", bad, coef_bus[bad*DATA_W +: DATA_W], mactive[bad]);
        end
      end
      chk("cfg_busy_vs_model", cfg_busy, mpend);
      chk("step_clear_exclusive", filt_step & filt_clear, 1'b0);
      if (s_ready) chk("s_ready_while_busy", cfg_busy, 1'b0);
      if (filt_step) begin
        chk("one_step_per_sample", steps + 1, accepts);
        chk("filt_x_at_step", filt_x, last_acc);
        steps++;
      end
      if (m_valid && !prev_mv) chk("accept_to_mvalid_latency", cyc - acc_cyc, 2);
      if (m_valid && prev_mv) chk("m_data_stable", m_data, prev_md);
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output got=%0d exp=none", m_data);
        end else begin
          chk("m_data_scoreboard", m_data, expq.pop_front());
        end
        got.push_back(m_data);
      end
      if (s_valid && s_ready) begin
        expq.push_back(3 * s_data + mactive[0]);
        accepts++; acc_cyc = cyc; last_acc = s_data;
      end
      if (cfg_we && !cfg_busy && cfg_addr < NCOEF) mshadow[cfg_addr] = cfg_wdata;
      if (cfg_commit && !cfg_busy) begin
        mpend = 1'b1;
        for (int k = 0; k < NCOEF; k++) mcommit[k] = mshadow[k];
      end
      if (filt_clear && mpend) begin
        swap_next = 1'b1; mpend = 1'b0;
      end
      prev_mv = m_valid; prev_md = m_data;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, output int acc);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d;
    while (!s_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout got=%0d exp=accepted", d);
    end
    tick();
    acc = cyc;
    s_valid = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, hs;
    accepts = 0; steps = 0; acc_cyc = 0; last_acc = '0;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    tick(); tick(); tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_filt_x", filt_x, 0);
    chk("rst_filt_step", filt_step, 0);
    chk("rst_filt_clear", filt_clear, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_coef_bus_zero", (coef_bus == '0), 1);
    reset = 1'b0; #1;
    chk("init_filt_clear", filt_clear, 1);
    chk("init_s_ready", s_ready, 0);
    tick();
    chk("idle_filt_clear", filt_clear, 0);
    chk("idle_s_ready", s_ready, 1);

    // back-to-back stream 1,2,3
    send(1, a0); send(2, a1); send(3, a2);
    chk("accept_spacing_1", a1 - a0, 3);
    chk("accept_spacing_2", a2 - a1, 3);
    tick(); tick();

    // back-pressure on sample 4, sample 5 waiting
    m_ready = 1'b0;
    send(4, a0);
    tick();
    s_valid = 1'b1; s_data = 5;
    for (int i = 0; i < 10; i++) begin
      chk("bp_m_data", m_data, 12);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_filt_step", filt_step, 0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    hs = cyc;
    chk("post_hs_s_ready", s_ready, 1);
    send(5, a1);
    chk("hs_to_accept", a1 - hs, 1);
    tick(); tick();

    // load b1 and a13 (a13 written in the commit cycle)
    cfg_we = 1'b1; cfg_addr = 0; cfg_wdata = 631178;
    tick();
    cfg_addr = 24; cfg_wdata = 379931; cfg_commit = 1'b1;
    chk("busy_before_commit", cfg_busy, 0);
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("busy_cycle1", cfg_busy, 1);
    chk("busy_cycle1_clear", filt_clear, 0);
    chk("busy_cycle1_s_ready", s_ready, 0);
    tick();
    chk("busy_cycle2", cfg_busy, 1);
    chk("swap_filt_clear", filt_clear, 1);
    chk("swap_b1_not_yet", coef_bus[0 +: 32], 0);
    tick();
    chk("busy_done", cfg_busy, 0);
    chk("after_swap_clear", filt_clear, 0);
    chk("b1_active", coef_bus[0 +: 32], 631178);
    chk("a13_active", coef_bus[24*32 +: 32], 379931);

    // out-of-range write and write while busy are dropped
    cfg_we = 1'b1; cfg_addr = 25; cfg_wdata = 32'hDEAD;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0; cfg_we = 1'b1; cfg_addr = 1; cfg_wdata = 32'h1234;
    tick(); tick();
    cfg_we = 1'b0;
    chk("busy_write_dropped", coef_bus[1*32 +: 32], 0);
    chk("b1_kept", coef_bus[0 +: 32], 631178);

    // commit during CALC: sample 7 uses old bank, sample 8 the new one
    cfg_we = 1'b1; cfg_addr = 0; cfg_wdata = 100;
    tick();
    cfg_we = 1'b0;
    send(7, a0);
    cfg_commit = 1'b1; s_valid = 1'b1; s_data = 8;
    tick();
    cfg_commit = 1'b0;
    chk("calc_commit_busy", cfg_busy, 1);
    chk("calc_commit_old_bank", coef_bus[0 +: 32], 631178);
    send(8, a1);
    tick(); tick();

    chk("got_count", got.size(), 7);
    if (got.size() >= 7) begin
      chk("got0", got[0], 3);
      chk("got1", got[1], 6);
      chk("got2", got[2], 9);
      chk("got3", got[3], 12);
      chk("got4", got[4], 15);
      chk("got5_old_bank", got[5], 631199);
      chk("got6_new_bank", got[6], 124);
    end

    // reset while in OUT with a commit pending
    m_ready = 1'b0;
    send(9, a0);
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("pre_rst_busy", cfg_busy, 1);
    chk("pre_rst_m_valid", m_valid, 1);
    chk("pre_rst_m_data", m_data, 127);
    reset = 1'b1; #1;
    chk("rst_out_m_valid", m_valid, 0);
    chk("rst_out_busy", cfg_busy, 0);
    chk("rst_out_m_data", m_data, 0);
    chk("rst_out_b1", coef_bus[0 +: 32], 0);
    chk("rst_out_clear", filt_clear, 0);
    tick();
    reset = 1'b0; m_ready = 1'b1; #1;
    chk("reinit_clear", filt_clear, 1);
    chk("reinit_s_ready", s_ready, 0);
    tick();
    chk("reidle_s_ready", s_ready, 1);
    chk("reidle_clear", filt_clear, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
